// File: rtl/timer_pkg.sv
// timer_pkg -- shared definitions for the timer arbiter slice.
//   state_e            : arbiter FSM states (encoding is fixed here)
//   DELAY_W            : width of one requester's delay field
//   DEF_N_REQ          : default number of requesters
//   DEF_SETTLE_CYC     : default cycles during which tmr_rdy is ignored after a load
//   TMR_OP_SCALE_BIT   : tmr_op bit carrying the range select
//                        (0 = delay in low 24 bits, 1 = delay in high 24 bits)
//   idx_width()        : index width for a vector of n entries (at least 1)
package timer_pkg;

  localparam int DELAY_W          = 24;
  localparam int DEF_N_REQ        = 4;
  localparam int DEF_SETTLE_CYC   = 3;
  localparam int TMR_OP_W         = 4;
  localparam int TMR_ADDR_W       = 8;
  localparam int TMR_DATA_W       = 16;
  localparam int TMR_OP_SCALE_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- combinational round-robin picker.
//   req    : request vector
//   last_g : index of the previous winner; the search starts at last_g+1
//   gnt    : one-hot grant (all zero when no request)
//   idx    : index of the granted requester
//   valid  : at least one request present
module rr_arbiter
  import timer_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_g,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // cand[k] is the requester examined at priority position k.
  logic [IDX_W-1:0] cand [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign cand[gi] = IDX_W'((int'(last_g) + gi + 1) % N_REQ);
  end

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!valid && req[cand[k]]) begin
        valid         = 1'b1;
        idx           = cand[k];
        gnt[cand[k]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter -- shares one 48-bit down-counter timer among N_REQ requesters.
//   clk, rst_n : clock; asynchronous active-low reset
//   req        : level request per requester (held until done or abandoned)
//   delay      : flat delays, slice i = delay[24*i +: 24]
//   scale      : per-requester range select (1 = delay placed in upper 24 bits)
//   gnt        : registered one-hot grant, high from LOAD through DONE
//   done       : one-cycle completion pulse to the granted requester
//   busy       : FSM not in IDLE
//   tmr_cs     : one-cycle timer load strobe (LOAD state)
//   tmr_op     : {3'b000, scale[g]}
//   tmr_addr   : delay[g][23:16]
//   tmr_data   : delay[g][15:0]
//   tmr_rdy    : timer terminal-count flag
// The timer itself lives at the parent level. SETTLE_CYC values below 1 are
// treated as 1 (SETTLE always lasts at least one cycle).
module timer_arbiter
  import timer_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DELAY_W-1:0] delay,
  input  logic [N_REQ-1:0]         scale,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic                     tmr_cs,
  output logic [TMR_OP_W-1:0]      tmr_op,
  output logic [TMR_ADDR_W-1:0]    tmr_addr,
  output logic [TMR_DATA_W-1:0]    tmr_data,
  input  logic                     tmr_rdy
);

  localparam int IDX_W      = idx_width(N_REQ);
  localparam int SETTLE_EFF = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  localparam int CNT_W      = idx_width(SETTLE_EFF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 1);

  state_e                 state_q, state_d;
  logic [N_REQ-1:0]       gnt_q, gnt_d;
  logic [IDX_W-1:0]       g_q, g_d;
  logic [IDX_W-1:0]       last_g_q, last_g_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TMR_OP_W-1:0]    op_q, op_d;
  logic [TMR_ADDR_W-1:0]  addr_q, addr_d;
  logic [TMR_DATA_W-1:0]  data_q, data_d;

  logic [DELAY_W-1:0]     delay_arr [N_REQ];
  logic [N_REQ-1:0]       arb_gnt;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_valid;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_delay
    assign delay_arr[gi] = delay[DELAY_W*gi +: DELAY_W];
  end

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req    (req),
    .last_g (last_g_q),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .valid  (arb_valid)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    g_d      = g_q;
    last_g_d = last_g_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d  = ST_LOAD;
          gnt_d    = arb_gnt;
          g_d      = arb_idx;
          last_g_d = arb_idx;
          // Timer command is captured with the grant so it stays stable
          // through the whole operation and until the next grant.
          op_d                   = '0;
          op_d[TMR_OP_SCALE_BIT] = scale[arb_idx];
          addr_d                 = delay_arr[arb_idx][DELAY_W-1:TMR_DATA_W];
          data_d                 = delay_arr[arb_idx][TMR_DATA_W-1:0];
        end
      end
      ST_LOAD: begin
        // req[g] is deliberately not looked at here.
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
      ST_SETTLE: begin
        if (!req[g_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        // Abandon wins over a coincident rdy: no done for a dropped request.
        if (!req[g_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (tmr_rdy) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      g_q      <= '0;
      last_g_q <= IDX_W'(N_REQ - 1);
      cnt_q    <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      g_q      <= g_d;
      last_g_q <= last_g_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Outputs decode registered state only, so reset clears them immediately.
  assign gnt      = gnt_q;
  assign done     = (state_q == ST_DONE) ? gnt_q : '0;
  assign busy     = (state_q != ST_IDLE);
  assign tmr_cs   = (state_q == ST_LOAD);
  assign tmr_op   = op_q;
  assign tmr_addr = addr_q;
  assign tmr_data = data_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter -- scoreboard bench for timer_arbiter with a behavioural
// 48-bit down-counter timer (one-cycle load latency, rdy high at zero).
module tb_timer_arbiter;

  localparam int N_REQ      = 4;
  localparam int SETTLE_CYC = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [95:0] delay = '0;
  logic [3:0]  scale = '0;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic        tmr_cs;
  logic [3:0]  tmr_op;
  logic [7:0]  tmr_addr;
  logic [15:0] tmr_data;
  logic        tmr_rdy;

  logic [47:0] tcnt = '0;
  logic        rdy_force = 1'b0;

  timer_arbiter #(
    .N_REQ      (N_REQ),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .delay    (delay),
    .scale    (scale),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .tmr_cs   (tmr_cs),
    .tmr_op   (tmr_op),
    .tmr_addr (tmr_addr),
    .tmr_data (tmr_data),
    .tmr_rdy  (tmr_rdy)
  );

  always #5 clk = ~clk;

  // Timer model: not reset by the arbiter's reset, keeps counting.
  assign tmr_rdy = rdy_force | (tcnt == 48'd0);
  always @(posedge clk) begin
    if (tmr_cs)
      tcnt <= tmr_op[0] ? {tmr_addr, tmr_data, 24'd0} : {24'd0, tmr_addr, tmr_data};
    else if (tcnt != 48'd0)
      tcnt <= tcnt - 48'd1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int         idx;
    logic [3:0] op;
    logic [7:0] addr;
    logic [15:0] data;
    bit         want_done;
    int         lat;       // cycles from tmr_cs to done, -1 = not checked
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  bit   have_cur = 1'b0;
  int   cyc = 0;
  int   cs_cyc = 0;
  int   n_cs = 0;
  int   n_done = 0;

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    cyc++;
    if (busy) begin
      check_eq("gnt_onehot", 64'($onehot(gnt)), 64'd1);
      check_eq("done_onehot0", 64'($onehot0(done)), 64'd1);
    end
    if (tmr_cs) begin
      if (exp_q.size() == 0) begin
        check_eq("cs_unexpected", 64'd1, 64'd0);
      end else begin
        cur      = exp_q.pop_front();
        have_cur = 1'b1;
        cs_cyc   = cyc;
        n_cs++;
        check_eq("cs_gnt", 64'(gnt), 64'(4'b0001 << cur.idx));
        check_eq("cs_op", 64'(tmr_op), 64'(cur.op));
        check_eq("cs_addr", 64'(tmr_addr), 64'(cur.addr));
        check_eq("cs_data", 64'(tmr_data), 64'(cur.data));
        check_eq("cs_busy", 64'(busy), 64'd1);
        $display("txn load req=%0d op=%0h addr=%02h data=%04h cyc=%0d",
                 cur.idx, tmr_op, tmr_addr, tmr_data, cyc);
      end
    end
    if (done != 4'd0) begin
      n_done++;
      check_eq("done_wanted", 64'(have_cur && cur.want_done), 64'd1);
      check_eq("done_idx", 64'(done), 64'(4'b0001 << cur.idx));
      check_eq("done_gnt", 64'(gnt), 64'(done));
      if (cur.lat >= 0)
        check_eq("done_lat", 64'(cyc - cs_cyc), 64'(cur.lat));
      $display("txn done req=%0d latency=%0d", cur.idx, cyc - cs_cyc);
    end
  end

  task automatic push(input int idx, input logic [23:0] d, input bit sc,
                      input bit want, input int lat);
    txn_t t;
    t.idx       = idx;
    t.op        = {3'b000, sc};
    t.addr      = d[23:16];
    t.data      = d[15:0];
    t.want_done = want;
    t.lat       = lat;
    exp_q.push_back(t);
  endtask

  task automatic set_req(input int idx, input logic [23:0] d, input bit sc);
    delay[24*idx +: 24] = d;
    scale[idx]          = sc;
    req[idx]            = 1'b1;
  endtask

  task automatic wait_cs(input int target, input int max_cyc, input string tag);
    int n = 0;
    while (n_cs < target && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq(tag, 64'(n_cs), 64'(target));
  endtask

  task automatic wait_done(input int target, input int max_cyc, input string tag);
    int n = 0;
    while (n_done < target && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq(tag, 64'(n_done), 64'(target));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    exp_q.delete();
    have_cur = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_gnt"}, 64'(gnt), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_cs"}, 64'(tmr_cs), 64'd0);
    check_eq({tag, "_op"}, 64'(tmr_op), 64'd0);
    check_eq({tag, "_addr"}, 64'(tmr_addr), 64'd0);
    check_eq({tag, "_data"}, 64'(tmr_data), 64'd0);
  endtask

  initial begin
    int base_cs;
    int base_done;

    // Reset state
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, delay 100
    push(0, 24'd100, 1'b0, 1'b1, 102);
    set_req(0, 24'd100, 1'b0);
    wait_cs(1, 20, "single_cs");
    wait_done(1, 200, "single_done");
    req[0] = 1'b0;
    check_eq("single_busy_after", 64'(busy), 64'd0);
    check_eq("single_gnt_after", 64'(gnt), 64'd0);

    // Contention: all four, delay 10, order 0,1,2,3,0
    do_reset();
    base_cs = n_cs; base_done = n_done;
    for (int i = 0; i < 4; i++) delay[24*i +: 24] = 24'd10;
    push(0, 24'd10, 1'b0, 1'b1, 12);
    push(1, 24'd10, 1'b0, 1'b1, 12);
    push(2, 24'd10, 1'b0, 1'b1, 12);
    push(3, 24'd10, 1'b0, 1'b1, 12);
    push(0, 24'd10, 1'b0, 1'b1, 12);
    req = 4'b1111;
    wait_done(base_done + 5, 200, "contend_done");
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("contend_cs_count", 64'(n_cs - base_cs), 64'd5);
    check_eq("contend_busy_after", 64'(busy), 64'd0);

    // Zero delay with rdy already high before load
    do_reset();
    base_done = n_done;
    rdy_force = 1'b1;
    push(1, 24'd0, 1'b0, 1'b1, SETTLE_CYC + 2);
    set_req(1, 24'd0, 1'b0);
    wait_done(base_done + 1, 40, "zero_done");
    req[1] = 1'b0;
    rdy_force = 1'b0;

    // Abandon mid-RUN; pending req[3] granted next
    do_reset();
    base_cs = n_cs; base_done = n_done;
    push(1, 24'd1000, 1'b0, 1'b0, -1);
    push(3, 24'd10, 1'b0, 1'b1, 12);
    set_req(1, 24'd1000, 1'b0);
    set_req(3, 24'd10, 1'b0);
    wait_cs(base_cs + 1, 20, "abandon_cs1");
    repeat (20) @(posedge clk);
    #1;
    req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("abandon_busy", 64'(busy), 64'd0);
    check_eq("abandon_gnt", 64'(gnt), 64'd0);
    @(negedge clk);
    check_eq("abandon_next_cs", 64'(tmr_cs), 64'd1);
    check_eq("abandon_next_gnt", 64'(gnt), 64'b1000);
    wait_done(base_done + 1, 40, "abandon_done3");
    req[3] = 1'b0;

    // Scale: delay 1 in the upper range, must not complete early
    do_reset();
    base_cs = n_cs; base_done = n_done;
    push(2, 24'h000001, 1'b1, 1'b0, -1);
    set_req(2, 24'h000001, 1'b1);
    wait_cs(base_cs + 1, 20, "scale_cs");
    repeat (300) @(posedge clk);
    #1;
    check_eq("scale_busy", 64'(busy), 64'd1);
    check_eq("scale_no_done", 64'(n_done), 64'(base_done));
    req[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("scale_busy_after", 64'(busy), 64'd0);

    // Reset asserted in RUN, then req[3] alone
    do_reset();
    base_cs = n_cs; base_done = n_done;
    push(0, 24'd1000, 1'b0, 1'b0, -1);
    set_req(0, 24'd1000, 1'b0);
    wait_cs(base_cs + 1, 20, "rst_cs");
    repeat (10) @(posedge clk);
    #2;
    check_eq("rst_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_async");
    req = '0;
    exp_q.delete();
    have_cur = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push(3, 24'd10, 1'b0, 1'b1, 12);
    set_req(3, 24'd10, 1'b0);
    wait_cs(base_cs + 2, 20, "rst_after_cs");
    wait_done(base_done + 1, 40, "rst_after_done");
    req[3] = 1'b0;

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the single 48-bit down-counter timer.
REQ-002 Parameter SETTLE_CYC, default 3: cycles after a load during which tmr_rdy is ignored.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  N_REQ  level request per requester; held high until done or abandoned.
REQ-006 delay  input  N_REQ*24  flat per-requester delay; slice i = delay[24*i+23:24*i].
REQ-007 scale  input  N_REQ  per-requester range select: 0 = delay in low 24 bits, 1 = delay in high 24 bits (x2^24).
REQ-008 gnt  output  N_REQ  one-hot grant, registered; high from LOAD through DONE.
REQ-009 done  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 tmr_cs  output  1  one-cycle load strobe to the timer.
REQ-012 tmr_op  output  4  {3'b000, scale[g]}, g = granted index.
REQ-013 tmr_addr  output  8  delay[g][23:16].
REQ-014 tmr_data  output  16  delay[g][15:0].
REQ-015 tmr_rdy  input  1  timer terminal-count flag (high at zero).

Function
REQ-016 States: IDLE, LOAD, SETTLE, RUN, DONE; encoding fixed in the package.
REQ-017 IDLE: if any req bit is high, register the winner index g, set gnt, go to LOAD; else stay.
REQ-018 Arbitration is round-robin: search starts at last_g+1 mod N_REQ; last_g updates only on entering LOAD.
REQ-019 LOAD lasts exactly one cycle: tmr_cs=1, tmr_op/addr/data driven from requester g; next state is SETTLE.
REQ-020 tmr_op/addr/data are registered when g is latched and are held stable from LOAD until the next grant.
REQ-021 SETTLE counts SETTLE_CYC cycles ignoring tmr_rdy, then goes to RUN, covering the timer's load latency and its stale rdy.
REQ-022 RUN: when tmr_rdy=1 is sampled, go to DONE; otherwise stay.
REQ-023 DONE lasts one cycle: done[g]=1, gnt[g]=1; next state is IDLE, with gnt cleared on the following edge.
REQ-024 Abandon: if req[g] falls in SETTLE or RUN, go to IDLE next cycle with no done pulse; the timer is not reloaded or stopped.
REQ-025 A req[g] fall during LOAD is ignored; it is evaluated from SETTLE onwards.
REQ-026 Non-granted req changes have no effect until IDLE.
REQ-027 A zero delay is legal: done follows SETTLE_CYC+2 cycles after tmr_cs.
REQ-028 A requester re-requesting immediately after done waits one IDLE cycle and then competes in round-robin order.
REQ-029 At most one gnt bit and one done bit are high in any cycle.
REQ-030 The block does no delay arithmetic: widths pass straight through, and the scale bit selects placement in the timer.

Reset
REQ-031 rst_n low: state=IDLE, gnt=0, done=0, busy=0, tmr_cs=0, tmr_op=0, tmr_addr=0, tmr_data=0, settle counter=0, last_g=N_REQ-1 (requester 0 wins first).
REQ-032 Reset mid-operation discards the grant with no done pulse; the timer keeps counting and its state is ignored after release.
REQ-033 Release of rst_n is synchronised externally; the first active edge after release evaluates IDLE.

Structure
REQ-034 Package timer_pkg holds the state enumeration, DELAY_W=24, the default N_REQ and SETTLE_CYC, and the tmr_op bit-0 scale meaning.
REQ-035 Sub-module rr_arbiter (req vector, last_g -> one-hot grant plus index) is purely combinational and instantiated once.
REQ-036 The timer is not instantiated inside this block; the arbiter connects to it at the parent level.

Verification
REQ-037 Single request: req[0]=1, delay=100, scale=0 -> tmr_cs one cycle with tmr_addr=0x00, tmr_data=0x0064, tmr_op=0; done[0] one cycle after the first rdy in RUN; busy then low.
REQ-038 Contention: req=4'b1111 held, all delays 10 -> grant order 0,1,2,3,0; exactly one done per grant; gnt always one-hot.
REQ-039 Scale: req[2]=1, delay=0x000001, scale=1 -> tmr_op=4'b0001, tmr_addr=0x00, tmr_data=0x0001; done not before 2^24 cycles.
REQ-040 Zero delay with a stale rdy high before load -> done exactly SETTLE_CYC+2 cycles after tmr_cs, never earlier.
REQ-041 Abandon: req[1] falls mid-RUN with delay 1000 -> no done[1]; busy low next cycle; a pending req[3] is granted in the following IDLE evaluation.
REQ-042 Reset asserted in RUN -> all outputs 0 asynchronously; after release req[3] alone is granted normally.
